muldiv_sequencer: RTL

- Multi-cycle sequencer for the MULT and DIV ALU operations. Picks up the 3-bit ALU control code produced by the ALU control decoder (MULT = 3'b010, DIV = 3'b011).
- Runs an iterative unsigned shift-add multiply or restoring divide, one bit per clock, and writes HI/LO result registers.
- Exposes a start/busy/done handshake so the core control FSM can stall the datapath while the operation runs.

---
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MULT/DIV sequencer, one bit per clock.
// Drives HI/LO with a start/busy/done handshake for the core stall logic.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic               accept;

  // One shift-add and one restoring-divide step computed from current state.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + ({1'b0, mcand} & {(WIDTH+1){acc[0]}});
    acc_nx   = {mul_sum, acc[WIDTH-1:1]};
    div_sh   = {rem, quo[WIDTH-1]};
    div_diff = div_sh - {1'b0, dvsr};
    div_ge   = (div_sh >= {1'b0, dvsr});
    rem_nx   = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    quo_nx   = {quo[WIDTH-2:0], div_ge};
    accept   = (state == IDLE) && start && !abort
             && ((op == OP_MULT) || (op == OP_DIV));
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      mcand       <= '0;
      dvsr        <= '0;
      rem         <= '0;
      quo         <= '0;
      acc         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_by_zero <= 1'b0;
            cnt         <= CW'(WIDTH-1);
            busy        <= 1'b1;
            mcand       <= a;
            dvsr        <= b;
            acc         <= {{WIDTH{1'b0}}, b};
            rem         <= '0;
            quo         <= a;
            if (op == OP_MULT) begin
              state <= MUL;
            end else if (b == '0) begin
              state       <= FIN;
              done        <= 1'b1;
              hi          <= a;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              state <= DIV;
            end
          end
        end
        MUL: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_nx;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
              state <= FIN;
              done  <= 1'b1;
              hi    <= acc_nx[2*WIDTH-1:WIDTH];
              lo    <= acc_nx[WIDTH-1:0];
            end
          end
        end
        DIV: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
              state <= FIN;
              done  <= 1'b1;
              hi    <= rem_nx;
              lo    <= quo_nx;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
